// File: rtl/dpll_pkg.sv
// Shared types and defaults for the DPLL phase detector / K-counter front end.
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_FIRST = 2'd1,
        FB_FIRST  = 2'd2
    } phase_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } vote_t;

    localparam int K_DEF    = 8;
    localparam int HOLD_MIN = 3;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; rise is a one-cycle pulse in the clk domain.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/phase_kcounter.sv
// DPLL front end: phase detector FSM between reference and feedback edges,
// feeding a random-walk K-counter that emits spaced inc/dec pulses.
module phase_kcounter
    import dpll_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int ACC_W   = 8,
    parameter int HOLD    = 4,
    parameter int MAX_WIN = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    refIn,
    input  logic                    fbIn,
    input  logic                    enable,
    output logic                    incOut,
    output logic                    decOut,
    output logic signed [ACC_W-1:0] acc,
    output logic                    lead,
    output logic                    lag,
    output logic                    slip
);

    localparam int WIN_W  = $clog2(MAX_WIN + 1);
    localparam int HOLD_W = $clog2(HOLD);

    localparam logic [WIN_W-1:0]         WIN_ZERO  = WIN_W'(0);
    localparam logic [WIN_W-1:0]         WIN_ONE   = WIN_W'(1);
    localparam logic [WIN_W-1:0]         WIN_LAST  = WIN_W'(MAX_WIN - 1);
    localparam logic [HOLD_W-1:0]        HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0]        HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]        HOLD_LOAD = HOLD_W'(HOLD - 1);
    localparam logic signed [ACC_W-1:0]  ACC_ZERO  = ACC_W'(0);
    localparam logic signed [ACC_W-1:0]  ACC_ONE   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  ACC_MAX   = ACC_W'(K - 1);
    localparam logic signed [ACC_W-1:0]  ACC_MIN   = -ACC_MAX;

    logic                    ref_edge_s;
    logic                    fb_edge_s;
    phase_state_t            state_r;
    phase_state_t            state_nxt_s;
    logic [WIN_W-1:0]        win_r;
    logic [WIN_W-1:0]        win_nxt_s;
    vote_t                   vote_s;
    logic                    slip_r;
    logic                    slip_nxt_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_nxt_s;
    logic [HOLD_W-1:0]       hold_r;
    logic [HOLD_W-1:0]       hold_nxt_s;
    logic                    inc_r;
    logic                    inc_nxt_s;
    logic                    dec_r;
    logic                    dec_nxt_s;

    edge_sync u_ref_sync (
        .clk   (clk),
        .reset (reset),
        .din   (refIn),
        .rise  (ref_edge_s)
    );

    edge_sync u_fb_sync (
        .clk   (clk),
        .reset (reset),
        .din   (fbIn),
        .rise  (fb_edge_s)
    );

    // Phase FSM: window opens on the first edge, closes on the other edge or timeout
    always_comb begin
        state_nxt_s = state_r;
        win_nxt_s   = win_r;
        vote_s      = NONE;
        slip_nxt_s  = 1'b0;
        if (!enable) begin
            state_nxt_s = IDLE;
            win_nxt_s   = WIN_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ref_edge_s && !fb_edge_s) begin
                        state_nxt_s = REF_FIRST;
                        win_nxt_s   = WIN_ZERO;
                    end else if (fb_edge_s && !ref_edge_s) begin
                        state_nxt_s = FB_FIRST;
                        win_nxt_s   = WIN_ZERO;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                REF_FIRST: begin
                    if (fb_edge_s) begin
                        state_nxt_s = IDLE;
                    end else if (win_r == WIN_LAST) begin
                        state_nxt_s = IDLE;
                        slip_nxt_s  = 1'b1;
                    end else begin
                        vote_s    = UP;
                        win_nxt_s = win_r + WIN_ONE;
                    end
                end
                FB_FIRST: begin
                    if (ref_edge_s) begin
                        state_nxt_s = IDLE;
                    end else if (win_r == WIN_LAST) begin
                        state_nxt_s = IDLE;
                        slip_nxt_s  = 1'b1;
                    end else begin
                        vote_s    = DN;
                        win_nxt_s = win_r + WIN_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    win_nxt_s   = WIN_ZERO;
                end
            endcase
        end
    end

    // K-counter: saturates at +-(K-1) while the hold-off is still running
    always_comb begin
        acc_nxt_s = acc_r;
        inc_nxt_s = 1'b0;
        dec_nxt_s = 1'b0;
        if (hold_r != HOLD_ZERO) begin
            hold_nxt_s = hold_r - HOLD_ONE;
        end else begin
            hold_nxt_s = HOLD_ZERO;
        end
        case (vote_s)
            UP: begin
                if (acc_r < ACC_MAX) begin
                    acc_nxt_s = acc_r + ACC_ONE;
                end else if (hold_r == HOLD_ZERO) begin
                    inc_nxt_s  = 1'b1;
                    acc_nxt_s  = ACC_ZERO;
                    hold_nxt_s = HOLD_LOAD;
                end else begin
                    acc_nxt_s = ACC_MAX;
                end
            end
            DN: begin
                if (acc_r > ACC_MIN) begin
                    acc_nxt_s = acc_r - ACC_ONE;
                end else if (hold_r == HOLD_ZERO) begin
                    dec_nxt_s  = 1'b1;
                    acc_nxt_s  = ACC_ZERO;
                    hold_nxt_s = HOLD_LOAD;
                end else begin
                    acc_nxt_s = ACC_MIN;
                end
            end
            default: begin
                acc_nxt_s = acc_r;
            end
        endcase
    end

    // Phase state, window count and slip registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            win_r   <= WIN_ZERO;
            slip_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            win_r   <= win_nxt_s;
            slip_r  <= slip_nxt_s;
        end
    end

    // Accumulator, hold-off and pulse output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r  <= ACC_ZERO;
            hold_r <= HOLD_ZERO;
            inc_r  <= 1'b0;
            dec_r  <= 1'b0;
        end else begin
            acc_r  <= acc_nxt_s;
            hold_r <= hold_nxt_s;
            inc_r  <= inc_nxt_s;
            dec_r  <= dec_nxt_s;
        end
    end

    assign incOut = inc_r;
    assign decOut = dec_r;
    assign acc    = acc_r;
    assign slip   = slip_r;
    assign lead   = (state_r == REF_FIRST);
    assign lag    = (state_r == FB_FIRST);

endmodule

// File: tb/tb_phase_kcounter.sv
// Directed bench for phase_kcounter: three parameterisations share one stimulus.
`timescale 1ns/1ps
module tb_phase_kcounter;

    logic clk = 1'b0;
    logic reset;
    logic refIn;
    logic fbIn;
    logic enable;

    logic a_inc, a_dec, a_lead, a_lag, a_slip;
    logic b_inc, b_dec, b_lead, b_lag, b_slip;
    logic c_inc, c_dec, c_lead, c_lag, c_slip;
    logic signed [7:0] a_acc, b_acc, c_acc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    phase_kcounter #(.K(4), .ACC_W(8), .HOLD(4), .MAX_WIN(16)) dut_a (
        .clk(clk), .reset(reset), .refIn(refIn), .fbIn(fbIn), .enable(enable),
        .incOut(a_inc), .decOut(a_dec), .acc(a_acc), .lead(a_lead), .lag(a_lag), .slip(a_slip)
    );

    phase_kcounter #(.K(2), .ACC_W(8), .HOLD(4), .MAX_WIN(255)) dut_b (
        .clk(clk), .reset(reset), .refIn(refIn), .fbIn(fbIn), .enable(enable),
        .incOut(b_inc), .decOut(b_dec), .acc(b_acc), .lead(b_lead), .lag(b_lag), .slip(b_slip)
    );

    phase_kcounter #(.K(8), .ACC_W(8), .HOLD(4), .MAX_WIN(255)) dut_c (
        .clk(clk), .reset(reset), .refIn(refIn), .fbIn(fbIn), .enable(enable),
        .incOut(c_inc), .decOut(c_dec), .acc(c_acc), .lead(c_lead), .lag(c_lag), .slip(c_slip)
    );

    typedef struct {
        logic              r;
        logic              f;
        logic              e;
        logic [4:0]        flags;   // {inc, dec, lead, lag, slip}
        logic signed [7:0] acc;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        refIn  = 1'b0;
        fbIn   = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic [4:0] flags,
                                input logic signed [7:0] a);
        vec_t v;
        v.r     = r;
        v.f     = f;
        v.e     = 1'b1;
        v.flags = flags;
        v.acc   = a;
        return v;
    endfunction

    initial begin
        int lag_rise;
        int pulses [3];
        int n_dec;
        int between;
        int bad_between;
        int lead_cnt;
        int slip_cnt;
        int slip_edge;
        int last_lead;
        int inc_cnt;
        int exp_acc;
        logic exp_lead;

        // dut_a (K=4, HOLD=4): lead window of 6 votes, then simultaneous edges
        vecs[0]  = mk(1'b1, 1'b0, 5'b00000, 8'sd0);
        vecs[1]  = mk(1'b1, 1'b0, 5'b00000, 8'sd0);
        vecs[2]  = mk(1'b1, 1'b0, 5'b00100, 8'sd0);
        vecs[3]  = mk(1'b1, 1'b0, 5'b00100, 8'sd1);
        vecs[4]  = mk(1'b1, 1'b0, 5'b00100, 8'sd2);
        vecs[5]  = mk(1'b1, 1'b0, 5'b00100, 8'sd3);
        vecs[6]  = mk(1'b1, 1'b0, 5'b10100, 8'sd0);
        vecs[7]  = mk(1'b1, 1'b1, 5'b00100, 8'sd1);
        vecs[8]  = mk(1'b1, 1'b1, 5'b00100, 8'sd2);
        vecs[9]  = mk(1'b1, 1'b1, 5'b00000, 8'sd2);
        vecs[10] = mk(1'b1, 1'b1, 5'b00000, 8'sd2);
        vecs[11] = mk(1'b0, 1'b0, 5'b00000, 8'sd2);
        vecs[12] = mk(1'b0, 1'b0, 5'b00000, 8'sd2);
        vecs[13] = mk(1'b0, 1'b0, 5'b00000, 8'sd2);
        vecs[14] = mk(1'b1, 1'b1, 5'b00000, 8'sd2);
        vecs[15] = mk(1'b1, 1'b1, 5'b00000, 8'sd2);
        vecs[16] = mk(1'b1, 1'b1, 5'b00000, 8'sd2);
        vecs[17] = mk(1'b1, 1'b1, 5'b00000, 8'sd2);
        vecs[18] = mk(1'b1, 1'b1, 5'b00000, 8'sd2);
        vecs[19] = mk(1'b1, 1'b1, 5'b00000, 8'sd2);

        // Reset held while the inputs toggle
        reset  = 1'b0;
        refIn  = 1'b0;
        fbIn   = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            refIn = i[0];
            fbIn  = i[1];
            tick();
            check("reset_flags",
                  {a_inc, a_dec, a_lead, a_lag, a_slip, b_inc, b_dec, b_lead, b_lag, b_slip,
                   c_inc, c_dec, c_lead, c_lag, c_slip}, 32'sd0);
            check("reset_acc", {a_acc, b_acc, c_acc}, 32'sd0);
        end
        refIn = 1'b0;
        fbIn  = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_quiet",
                  {a_inc, a_dec, a_lead, a_lag, a_slip, b_inc, b_dec, b_lead, b_lag, b_slip,
                   c_inc, c_dec, c_lead, c_lag, c_slip}, 32'sd0);
        end

        // Table: lead window and simultaneous edges on dut_a
        do_reset();
        for (int i = 0; i < 20; i++) begin
            refIn  = vecs[i].r;
            fbIn   = vecs[i].f;
            enable = vecs[i].e;
            tick();
            check($sformatf("vec%0d_flags", i), {a_inc, a_dec, a_lead, a_lag, a_slip},
                  vecs[i].flags);
            check($sformatf("vec%0d_acc", i), a_acc, vecs[i].acc);
        end

        // Lag with hold-off on dut_b (K=2): 10 down votes
        do_reset();
        lag_rise    = -1;
        n_dec       = 0;
        between     = 0;
        bad_between = 0;
        for (int s = 0; s < 18; s++) begin
            fbIn  = 1'b1;
            refIn = (s >= 11) ? 1'b1 : 1'b0;
            tick();
            if (b_lag && lag_rise < 0) lag_rise = s + 1;
            if (b_inc) check("lag_no_inc", b_inc, 32'sd0);
            if (n_dec >= 1 && n_dec < 3 && !b_dec) begin
                between++;
                if (b_acc != -8'sd1) bad_between++;
            end
            if (b_dec) begin
                if (n_dec < 3) pulses[n_dec] = s + 1;
                n_dec++;
            end
        end
        check("lag_dec_count", n_dec, 32'sd3);
        check("lag_first_pulse", pulses[0] - lag_rise, 32'sd2);
        check("lag_spacing_1", pulses[1] - pulses[0], 32'sd4);
        check("lag_spacing_2", pulses[2] - pulses[1], 32'sd4);
        check("lag_between_cycles", between, 32'sd6);
        check("lag_clamp_violations", bad_between, 32'sd0);
        check("lag_final_acc", b_acc, 32'sd0);
        check("lag_final_state", {b_lead, b_lag}, 32'sd0);

        // Slip on dut_a (MAX_WIN=16): reference with no feedback edge
        do_reset();
        lead_cnt  = 0;
        slip_cnt  = 0;
        slip_edge = -1;
        last_lead = -1;
        inc_cnt   = 0;
        for (int s = 0; s < 30; s++) begin
            refIn = 1'b1;
            tick();
            if (a_lead) begin
                lead_cnt++;
                last_lead = s + 1;
            end
            if (a_slip) begin
                slip_cnt++;
                slip_edge = s + 1;
            end
            if (a_inc) inc_cnt++;
        end
        check("slip_lead_cycles", lead_cnt, 32'sd16);
        check("slip_count", slip_cnt, 32'sd1);
        check("slip_after_lead", slip_edge - last_lead, 32'sd1);
        check("slip_inc_count", inc_cnt, 32'sd3);
        check("slip_final_acc", a_acc, 32'sd3);
        check("slip_idle", {a_lead, a_lag}, 32'sd0);

        // Enable drops 3 votes into a lead window on dut_c (K=8)
        do_reset();
        for (int s = 0; s < 12; s++) begin
            refIn  = 1'b1;
            enable = (s < 6 || s >= 10) ? 1'b1 : 1'b0;
            tick();
            exp_lead = (s + 1 >= 3 && s + 1 <= 6) ? 1'b1 : 1'b0;
            exp_acc  = (s + 1 <= 3) ? 0 : ((s + 1 >= 6) ? 3 : s + 1 - 3);
            check($sformatf("en_lead_%0d", s), c_lead, exp_lead);
            check($sformatf("en_acc_%0d", s), c_acc, exp_acc);
        end

        // Reset asserted mid-window with acc at 5 on dut_c
        do_reset();
        for (int s = 0; s < 8; s++) begin
            refIn = 1'b1;
            tick();
        end
        check("pre_reset_acc", c_acc, 32'sd5);
        reset = 1'b0;
        refIn = 1'b0;
        #1;
        check("async_reset_acc", c_acc, 32'sd0);
        check("async_reset_flags", {c_inc, c_dec, c_lead, c_lag, c_slip}, 32'sd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            check("post_release_quiet", {c_inc, c_dec, c_lead, c_lag, c_slip, c_acc}, 32'sd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
